// File: rtl/pwm_regs_pkg.sv
// rtl/pwm_regs_pkg.sv - PWM register map, function encodings and sequencer state type
package pwm_regs_pkg;

  localparam logic [5:0] ADDR_PERIOD        = 6'h00;
  localparam logic [5:0] ADDR_COUNTER_EN    = 6'h02;
  localparam logic [5:0] ADDR_COMPARE1      = 6'h03;
  localparam logic [5:0] ADDR_COUNTER_RESET = 6'h07;
  localparam logic [5:0] ADDR_PRESCALE      = 6'h0A;
  localparam logic [5:0] ADDR_PWM_EN        = 6'h0C;
  localparam logic [5:0] ADDR_FUNCTIONS     = 6'h0D;

  localparam logic [1:0] FUNC_ALIGN_LEFT             = 2'd0;
  localparam logic [1:0] FUNC_ALIGN_RIGHT            = 2'd1;
  localparam logic [1:0] FUNC_RANGE_BETWEEN_COMPARES = 2'd2;

  localparam logic [3:0] INIT_LAST_IDX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT,
    S_UPD_LO,
    S_UPD_HI,
    S_DONE,
    S_STOP
  } state_t;

endpackage

// File: rtl/pwm_bus_arbiter.sv
// rtl/pwm_bus_arbiter.sv - fixed-priority register-bus mux, SPI over sequencer, registered outputs
module pwm_bus_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       seq_req,
  input  logic [5:0] seq_addr,
  input  logic       seq_hi,
  input  logic [7:0] seq_wdata,
  output logic       seq_grant,
  input  logic       spi_wr_en,
  input  logic [5:0] spi_addr,
  input  logic       spi_hi,
  input  logic [7:0] spi_wdata,
  output logic       reg_wr_en,
  output logic [5:0] reg_addr,
  output logic       reg_hi,
  output logic [7:0] reg_wdata,
  output logic       spi_collision
);

  assign seq_grant = seq_req & ~spi_wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wr_en     <= 1'b0;
      reg_addr      <= '0;
      reg_hi        <= 1'b0;
      reg_wdata     <= '0;
      spi_collision <= 1'b0;
    end else begin
      reg_wr_en     <= spi_wr_en | seq_req;
      spi_collision <= spi_wr_en & seq_req;
      if (spi_wr_en) begin
        reg_addr  <= spi_addr;
        reg_hi    <= spi_hi;
        reg_wdata <= spi_wdata;
      end else if (seq_req) begin
        reg_addr  <= seq_addr;
        reg_hi    <= seq_hi;
        reg_wdata <= seq_wdata;
      end else begin
        reg_addr  <= '0;
        reg_hi    <= 1'b0;
        reg_wdata <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// rtl/pwm_ramp_sequencer.sv - programs the PWM block then ramps COMPARE1 one step per hold interval
module pwm_ramp_sequencer
  import pwm_regs_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [7:0]        cfg_prescale,
  input  logic [1:0]        cfg_function,
  input  logic [CNT_W-1:0]  ramp_start,
  input  logic [CNT_W-1:0]  ramp_end,
  input  logic [CNT_W-1:0]  ramp_step,
  input  logic [HOLD_W-1:0] ramp_hold,
  input  logic              period_tick,
  input  logic              spi_wr_en,
  input  logic [5:0]        spi_addr,
  input  logic              spi_hi,
  input  logic [7:0]        spi_wdata,
  output logic              reg_wr_en,
  output logic [5:0]        reg_addr,
  output logic              reg_hi,
  output logic [7:0]        reg_wdata,
  output logic              busy,
  output logic              done,
  output logic              spi_collision
);

  state_t state, state_next;

  logic [3:0]        idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cmp;

  logic [CNT_W-1:0]  sh_period, sh_start, sh_end, sh_step;
  logic [7:0]        sh_prescale;
  logic [1:0]        sh_function;
  logic [HOLD_W-1:0] sh_hold;

  logic       seq_req, seq_grant, seq_hi;
  logic [5:0] seq_addr;
  logic [7:0] seq_wdata;

  logic launch, abort, hold_hit, ramp_up;
  logic [HOLD_W-1:0] hold_eff;
  logic [HOLD_W:0]   hold_inc;
  logic [CNT_W:0]    sum, diff;
  logic [CNT_W-1:0]  cmp_next;
  logic [15:0]       period16, start16, cmp16;

  assign launch   = start & ~stop & ((state == S_IDLE) | (state == S_DONE));
  assign abort    = stop & (state != S_IDLE) & (state != S_STOP);
  assign hold_eff = (sh_hold == '0) ? HOLD_W'(1) : sh_hold;
  assign hold_inc = {1'b0, hold_cnt} + 1'b1;
  assign hold_hit = period_tick & (hold_inc >= {1'b0, hold_eff});
  assign ramp_up  = sh_end > sh_start;
  assign busy     = (state != S_IDLE) & (state != S_DONE);
  assign done     = (state == S_DONE);
  assign period16 = 16'(sh_period);
  assign start16  = 16'(sh_start);
  assign cmp16    = 16'(cmp);

  // One extra bit so the step can never wrap past ramp_end in either direction.
  always_comb begin
    sum  = {1'b0, cmp} + {1'b0, sh_step};
    diff = {1'b0, cmp} - {1'b0, sh_step};
    cmp_next = sh_end;
    if (ramp_up) begin
      if (sum < {1'b0, sh_end}) cmp_next = sum[CNT_W-1:0];
    end else begin
      if (!diff[CNT_W] && diff[CNT_W-1:0] > sh_end) cmp_next = diff[CNT_W-1:0];
    end
  end

  always_comb begin
    state_next = state;
    seq_req    = 1'b0;
    seq_addr   = '0;
    seq_hi     = 1'b0;
    seq_wdata  = '0;
    case (state)
      S_IDLE: if (launch) state_next = S_INIT;
      S_INIT: begin
        seq_req = 1'b1;
        case (idx)
          4'd0: begin seq_addr = ADDR_PERIOD;        seq_wdata = period16[7:0]; end
          4'd1: begin seq_addr = ADDR_PERIOD;        seq_hi = 1'b1; seq_wdata = period16[15:8]; end
          4'd2: begin seq_addr = ADDR_PRESCALE;      seq_wdata = sh_prescale; end
          4'd3: begin seq_addr = ADDR_COMPARE1;      seq_wdata = start16[7:0]; end
          4'd4: begin seq_addr = ADDR_COMPARE1;      seq_hi = 1'b1; seq_wdata = start16[15:8]; end
          4'd5: begin seq_addr = ADDR_FUNCTIONS;     seq_wdata = {6'd0, sh_function}; end
          4'd6: begin seq_addr = ADDR_COUNTER_RESET; seq_wdata = 8'd1; end
          4'd7: begin seq_addr = ADDR_COUNTER_RESET; seq_wdata = 8'd0; end
          4'd8: begin seq_addr = ADDR_COUNTER_EN;    seq_wdata = 8'd1; end
          default: begin seq_addr = ADDR_PWM_EN;     seq_wdata = 8'd1; end
        endcase
        if (seq_grant && idx == INIT_LAST_IDX)
          state_next = (sh_step == '0 || sh_start == sh_end) ? S_DONE : S_WAIT;
      end
      S_WAIT: if (hold_hit) state_next = S_UPD_LO;
      S_UPD_LO: begin
        seq_req   = 1'b1;
        seq_addr  = ADDR_COMPARE1;
        seq_wdata = cmp16[7:0];
        if (seq_grant) state_next = S_UPD_HI;
      end
      S_UPD_HI: begin
        seq_req   = 1'b1;
        seq_addr  = ADDR_COMPARE1;
        seq_hi    = 1'b1;
        seq_wdata = cmp16[15:8];
        if (seq_grant) state_next = (cmp == sh_end) ? S_DONE : S_WAIT;
      end
      S_DONE: if (launch) state_next = S_INIT;
      S_STOP: begin
        seq_req  = 1'b1;
        seq_addr = idx[0] ? ADDR_PWM_EN : ADDR_COUNTER_EN;
        if (seq_grant && idx[0]) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Dropping the request here keeps the arbiter from launching the abandoned beat.
    if (abort) begin
      state_next = S_STOP;
      seq_req    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      hold_cnt    <= '0;
      cmp         <= '0;
      sh_period   <= '0;
      sh_prescale <= '0;
      sh_function <= '0;
      sh_start    <= '0;
      sh_end      <= '0;
      sh_step     <= '0;
      sh_hold     <= '0;
    end else begin
      state <= state_next;
      if (launch) begin
        sh_period   <= cfg_period;
        sh_prescale <= cfg_prescale;
        sh_function <= cfg_function;
        sh_start    <= ramp_start;
        sh_end      <= ramp_end;
        sh_step     <= ramp_step;
        sh_hold     <= ramp_hold;
        cmp         <= ramp_start;
        hold_cnt    <= '0;
        idx         <= '0;
      end else if (abort) begin
        idx <= '0;
      end else if (seq_grant) begin
        idx <= (state_next != state) ? 4'd0 : idx + 4'd1;
      end
      if (state == S_WAIT && period_tick && !abort) begin
        if (hold_hit) begin
          hold_cnt <= '0;
          cmp      <= cmp_next;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

  pwm_bus_arbiter u_arb (
    .clk           (clk),
    .rst           (rst),
    .seq_req       (seq_req),
    .seq_addr      (seq_addr),
    .seq_hi        (seq_hi),
    .seq_wdata     (seq_wdata),
    .seq_grant     (seq_grant),
    .spi_wr_en     (spi_wr_en),
    .spi_addr      (spi_addr),
    .spi_hi        (spi_hi),
    .spi_wdata     (spi_wdata),
    .reg_wr_en     (reg_wr_en),
    .reg_addr      (reg_addr),
    .reg_hi        (reg_hi),
    .reg_wdata     (reg_wdata),
    .spi_collision (spi_collision)
  );

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
- Autonomous master on the internal register bus of the PWM generator. It programs a full PWM configuration, then ramps COMPARE1 from a start value to an end value, one step every HOLD period-wraps.
- Shares the register-bus write port with the SPI bridge through a fixed-priority arbiter; SPI always wins.
- Sits between the SPI bridge and the register file in top.

Parameters:
- CNT_W, 16, width of the PERIOD/COMPARE registers (written as low byte then high byte).
- HOLD_W, 8, width of the hold-period counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  pulse; begin a sequence (ignored unless IDLE or DONE)
- stop  in  1  pulse; abort and disable the PWM
- cfg_period  in  CNT_W  PERIOD value
- cfg_prescale  in  8  PRESCALE value
- cfg_function  in  2  FUNCTIONS[1:0]
- ramp_start  in  CNT_W  initial COMPARE1
- ramp_end  in  CNT_W  final COMPARE1
- ramp_step  in  CNT_W  unsigned step; 0 = no ramp
- ramp_hold  in  HOLD_W  period-wraps per step; 0 treated as 1
- period_tick  in  1  one-clk pulse when the counter wraps
- spi_wr_en  in  1  SPI bridge write strobe
- spi_addr  in  6  SPI register address
- spi_hi  in  1  SPI byte select (1 = bits [15:8])
- spi_wdata  in  8  SPI write data
- reg_wr_en  out  1  register-file write strobe
- reg_addr  out  6  register address
- reg_hi  out  1  byte select
- reg_wdata  out  8  write data
- busy  out  1  sequence in progress
- done  out  1  ramp reached ramp_end; held until next start
- spi_collision  out  1  one-clk pulse: a sequencer write was deferred by SPI

Behaviour:
- Reset: all outputs 0, state IDLE, internal compare = 0.
- Register map: PERIOD 0x00, COUNTER_EN 0x02, COMPARE1 0x03, COUNTER_RESET 0x07, PRESCALE 0x0A, PWM_EN 0x0C, FUNCTIONS 0x0D.
- Bus outputs are registered, so latency from an arbitration decision to the bus is 1 clk.
- Arbiter: if spi_wr_en=1, that cycle's bus beat is the SPI write and any pending sequencer write stalls, then retries next cycle. Every sequencer write is eventually issued exactly once, and its order is preserved.
- start samples all cfg_* and ramp_* inputs into shadow registers. Later input changes have no effect until the next start.
- States:
  - IDLE: wait for start.
  - INIT: issue the write list in order, one write per granted cycle:
    1. PERIOD lo, PERIOD hi
    2. PRESCALE
    3. COMPARE1 lo, COMPARE1 hi (value ramp_start)
    4. FUNCTIONS
    5. COUNTER_RESET=1, COUNTER_RESET=0
    6. COUNTER_EN=1, PWM_EN=1

    The list is 10 writes. Then go to WAIT, or straight to DONE if ramp_step=0 or ramp_start=ramp_end.
  - WAIT: count period_tick pulses. On the ramp_hold-th pulse, compute the next compare value and go to UPD_LO.
  - UPD_LO, UPD_HI: write COMPARE1 lo then hi.
  - UPD_HI: when complete, go to DONE if compare=ramp_end, else back to WAIT with the hold counter cleared.
  - DONE: done=1, busy=0. PWM keeps running.
  - STOP: write COUNTER_EN=0, then PWM_EN=0, then go to IDLE.
- busy=1 in INIT, WAIT, UPD_*, STOP.
- Ramp direction: up if ramp_end > ramp_start, else down.
- Next-value arithmetic is done in CNT_W+1 bits and saturates at ramp_end, never overshooting. Example: 3 + 4 with end 5 gives 5.
- period_tick is ignored outside WAIT. A tick in the same cycle as the WAIT entry is not counted.
- stop has priority over start and over any state. In IDLE, stop is ignored. Elsewhere, stop abandons any pending write and goes to STOP; a write already on the bus completes.
- start while busy is ignored. start in DONE restarts from INIT with the new config.
- rst mid-sequence returns the block to IDLE immediately, with outputs 0. Register-file contents are not restored.

Decomposition:
- Shared package pwm_regs_pkg holds:
  - the register address constants
  - the FUNCTION encodings (ALIGN_LEFT=0, ALIGN_RIGHT=1, RANGE_BETWEEN_COMPARES=2)
  - the state enum
- One sub-module: pwm_bus_arbiter, holding the 2-master fixed-priority mux, the registered outputs and the stall/grant signal.

Test Plan:
- start with period=7, prescale=0, function=0, ramp 3->3, step 1 -> exactly 10 bus writes in listed order, no SPI traffic in between; done=1; PWM high 4 of 8 clks.
- Ramp 1->7, step 2, hold 2 -> COMPARE1 takes 1,3,5,7; each update follows exactly 2 period_ticks; done after the 7 write.
- Ramp 6->0, step 4 -> COMPARE1 takes 6,2,0 (saturated); done asserted.
- spi_wr_en held for 3 cycles during INIT write 4 -> SPI writes appear on the bus; sequencer write 4 is delayed 3 clks and issued once; spi_collision pulses 3 times; order unchanged.
- stop in WAIT -> COUNTER_EN=0 then PWM_EN=0 written; IDLE; pwm_out stays low.
- rst asserted mid-UPD_LO -> all outputs 0 asynchronously; next start reruns the full INIT.
